scpu_sram_host_port: RTL and testbench
======================================

Name: scpu_sram_host_port

Overview:
- Host-side serial access port and on-chip byte SRAM: the host-access subsystem of the SCPU/SRAM/ALU top.
- An external controller shifts a 17-bit {address, data} word in serially, then commands a write into or a read from a 512 x 8 SRAM, or shifts the register back out.
- The SRAM holds CPU program and data bytes. Byte pairs are little-endian: even address = low byte.
- The CPU, ALU/CORDIC and SPI sections of the top are out of scope for this block.

Parameters:
- MEMORY_DATA_WIDTH, 8, SRAM word width in bits.
- MEMORY_ADDR_WIDTH, 9, SRAM address width; depth is 2^9 = 512.
- REG_BITS_WIDTH, MEMORY_ADDR_WIDTH+MEMORY_DATA_WIDTH (17), width of the serial shift register.

Ports:
- CLK  in  1  single system clock; all logic on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- CTRL_MODE  in  2  command: 00 shift-in, 01 SRAM read, 11 SRAM write, 10 shift-out.
- CTRL_BGN  in  1  command enable; must stay 1 for the whole command.
- LOAD_N  in  1  active-low command trigger.
- CTRL_SI  in  1  serial data in, LSB first.
- CTRL_RDY  out  1  command complete.
- CTRL_SO  out  1  serial data out, LSB first.

Behaviour:
- Internal register reg_bits[16:0]: address in [16:8], data in [7:0].
- Reset (RST_N=0 at a clock edge):
  - state goes to IDLE; reg_bits=0; CTRL_RDY=0; CTRL_SO=0.
  - SRAM contents are not cleared.
- States: IDLE, ARM, SHIFT_IN, ACCESS, SHIFT_OUT, DONE.
- IDLE:
  - If CTRL_BGN=1 and LOAD_N=0, latch CTRL_MODE and go to ARM.
  - CTRL_MODE is ignored for the rest of the command.
- ARM: one dead cycle, then:
  - mode 00 -> SHIFT_IN
  - mode 10 -> SHIFT_OUT
  - mode 01 or 11 -> ACCESS
- SHIFT_IN:
  - Runs exactly 17 clocks; each clock reg_bits <= {CTRL_SI, reg_bits[16:1]}.
  - The first sampled bit ends in reg_bits[0].
  - Sample alignment: LOAD_N seen low at edge n; CTRL_SI bit j is sampled at edge n+2+j.
  - Then go to DONE.
- SHIFT_OUT:
  - CTRL_SO = reg_bits[0].
  - Each clock, rotate reg_bits right ({reg_bits[0], reg_bits[16:1]}); 17 clocks.
  - reg_bits is restored to its original value at the end. Then go to DONE.
- ACCESS (one clock):
  - mode 11: SRAM[reg_bits[16:8]] <= reg_bits[7:0].
  - mode 01: reg_bits[7:0] <= SRAM[reg_bits[16:8]]; address bits unchanged.
  - Then go to DONE.
- DONE:
  - CTRL_RDY=1, held while CTRL_BGN=1.
  - When CTRL_BGN=0, go to IDLE; CTRL_RDY=0 from the next cycle.
- CTRL_RDY is 1 only in DONE.
- Abort: CTRL_BGN=0 in ARM, SHIFT_IN, SHIFT_OUT or ACCESS returns the FSM to IDLE.
  - No SRAM write occurs unless ACCESS has already executed.
  - reg_bits keeps its partial contents; CTRL_RDY is not asserted.
- LOAD_N is only examined in IDLE. A re-trigger needs a pass through IDLE, and LOAD_N must be low there.
- Reset mid-command: immediate return to IDLE. An in-flight SRAM write is not performed unless its ACCESS edge completed before reset.
- The 9-bit address covers all 512 locations; there is no out-of-range case.
- The SRAM is synchronous: read data is captured in ACCESS, write committed in ACCESS.
- Latency from the LOAD_N edge to CTRL_RDY:
  - shift-in and shift-out: 19 clocks
  - read and write: 3 clocks

Test Plan:
- Reset:
  - Action: hold RST_N=0 for 2 clocks with CTRL_BGN=1 and LOAD_N=0.
  - Expected: CTRL_RDY=0 and CTRL_SO=0 throughout; no command starts until after release.
- Shift-in then write then read:
  - Action: shift in {addr 0x004, data 0x58}; write (mode 11); shift in {0x004, 0x00}; read (mode 01).
  - Expected: reg_bits[7:0]=0x58.
  - Action: repeat for 0x005=0x00.
  - Expected: 16-bit value 88.
- Pout pair:
  - Action: write 0x006=0x71 and 0x007=0x01; read both back.
  - Expected: 0x0171 = 369.
  - Action: write 0x1FF=0xA5; read it back.
  - Expected: 0xA5 (boundary address).
- Shift-out:
  - Action: after shifting in 0x0_0AB (address 0x000, data 0xAB), run mode 10.
  - Expected: CTRL_SO emits 1,1,0,1,0,1,0,1, then nine 0s.
  - Expected: reg_bits equals 0x000AB afterwards.
- Handshake:
  - Expected: CTRL_RDY rises 19 clocks after a shift-in trigger and 3 clocks after a read/write trigger.
  - Expected: it stays high while CTRL_BGN=1 and drops one cycle after CTRL_BGN=0.
- Abort:
  - Action: drop CTRL_BGN during shift-in bit 8; then attempt a write.
  - Expected: no CTRL_RDY; the FSM returns to IDLE; SRAM is unchanged.
  - Expected: a subsequent full command works normally.

Source files
------------

// File: rtl/scpu_sram_host_port.sv
// Host serial access port with a 512 x 8 byte SRAM.
// A 17-bit {address, data} register is shifted in or out, or used to access the SRAM.
module scpu_sram_host_port #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] CTRL_MODE,
    input  logic       CTRL_BGN,
    input  logic       LOAD_N,
    input  logic       CTRL_SI,
    output logic       CTRL_RDY,
    output logic       CTRL_SO
);

    localparam int DW    = MEMORY_DATA_WIDTH;
    localparam int AW    = MEMORY_ADDR_WIDTH;
    localparam int RW    = REG_BITS_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(RW);

    localparam logic [CW-1:0] CNT_LAST = CW'(RW - 1);

    localparam logic [1:0] MODE_SHIFT_IN  = 2'b00;
    localparam logic [1:0] MODE_SHIFT_OUT = 2'b10;
    localparam logic [1:0] MODE_WRITE     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SHIFT_IN,
        S_ACCESS,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [RW-1:0]   reg_bits_q, reg_bits_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rdy_q, rdy_d;

    logic [DW-1:0]   mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;

    assign mem_addr  = reg_bits_q[RW-1:DW];
    assign mem_rdata = mem_q[mem_addr];

    // Next-state, register update and SRAM write-enable decode
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        reg_bits_d = reg_bits_q;
        cnt_d      = cnt_q;
        mem_we     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (CTRL_BGN && !LOAD_N) begin
                    mode_d  = CTRL_MODE;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                cnt_d = '0;
                if (!CTRL_BGN) begin
                    state_d = S_IDLE;
                end else if (mode_q == MODE_SHIFT_IN) begin
                    state_d = S_SHIFT_IN;
                end else if (mode_q == MODE_SHIFT_OUT) begin
                    state_d = S_SHIFT_OUT;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_SHIFT_IN: begin
                if (!CTRL_BGN) begin
                    state_d = S_IDLE;
                end else begin
                    reg_bits_d = {CTRL_SI, reg_bits_q[RW-1:1]};
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT_OUT: begin
                if (!CTRL_BGN) begin
                    state_d = S_IDLE;
                end else begin
                    reg_bits_d = {reg_bits_q[0], reg_bits_q[RW-1:1]};
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                if (!CTRL_BGN) begin
                    state_d = S_IDLE;
                end else begin
                    if (mode_q == MODE_WRITE) begin
                        mem_we = 1'b1;
                    end else begin
                        reg_bits_d[DW-1:0] = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!CTRL_BGN) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rdy_d = (state_q == S_DONE) && CTRL_BGN;
    end

    // Control and shift-register state with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            reg_bits_q <= '0;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            reg_bits_q <= reg_bits_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
        end
    end

    // SRAM write port; contents survive reset, writes are blocked while reset is held
    always_ff @(posedge CLK) begin
        if (mem_we && RST_N) begin
            mem_q[mem_addr] <= reg_bits_q[DW-1:0];
        end
    end

    assign CTRL_RDY = rdy_q;
    assign CTRL_SO  = (state_q == S_SHIFT_OUT) && reg_bits_q[0];

endmodule

// File: tb/tb_scpu_sram_host_port.sv
// Bench for scpu_sram_host_port: directed table, corner sequences and
// randomized commands checked against a behavioural register/memory model.
module tb_scpu_sram_host_port;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       bgn = 1'b0;
    logic       load_n = 1'b1;
    logic       si = 1'b0;
    logic       rdy;
    logic       so;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mmem [512];
    logic [16:0] mreg;

    always #5 clk = ~clk;

    scpu_sram_host_port dut (
        .CLK(clk),
        .RST_N(rst_n),
        .CTRL_MODE(mode),
        .CTRL_BGN(bgn),
        .LOAD_N(load_n),
        .CTRL_SI(si),
        .CTRL_RDY(rdy),
        .CTRL_SO(so)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] m);
        return (m == 2'b00 || m == 2'b10) ? 19 : 3;
    endfunction

    task automatic model_apply(input logic [1:0] m, input logic [16:0] w);
        case (m)
            2'b00: mreg = w;
            2'b11: mmem[mreg[16:8]] = mreg[7:0];
            2'b01: mreg[7:0] = mmem[mreg[16:8]];
            default: ;
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] m, input logic [16:0] w,
                           input string tag, input logic [16:0] exp_so,
                           input int exp_lat, input bit chk_so,
                           output logic [16:0] sw);
        int lat;
        lat = 0;
        sw = '0;
        @(posedge clk);
        #1;
        mode = m;
        bgn = 1'b1;
        load_n = 1'b0;
        si = 1'b0;
        @(posedge clk);
        #1;
        load_n = 1'b1;
        mode = 2'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            si = (k <= 17) ? w[k-1] : 1'b0;
            @(negedge clk);
            if (k <= 17) sw[k-1] = so;
            if (rdy) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        if (lat != 0) begin
            repeat (2) begin
                @(negedge clk);
                check({tag, " rdy hold"}, int'(rdy), 1);
            end
        end
        @(posedge clk);
        #1;
        bgn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " rdy drop"}, int'(rdy), 0);
        if (chk_so) check({tag, " so word"}, int'(sw), int'(exp_so));
    endtask

    task automatic do_cmd(input logic [1:0] m, input logic [16:0] w,
                          input string tag, output logic [16:0] sw);
        logic [16:0] e;
        e = mreg;
        run_cmd(m, w, tag, e, lat_of(m), m == 2'b10, sw);
        model_apply(m, w);
    endtask

    task automatic abort_cmd(input logic [1:0] m, input logic [16:0] w,
                             input int d, input string tag);
        int seen;
        int r;
        int s;
        seen = 0;
        @(posedge clk);
        #1;
        mode = m;
        bgn = 1'b1;
        load_n = 1'b0;
        @(posedge clk);
        #1;
        load_n = 1'b1;
        if (d == 0) bgn = 1'b0;
        for (int k = 1; k <= d; k++) begin
            @(posedge clk);
            #1;
            si = w[k-1];
            if (k == d) bgn = 1'b0;
        end
        repeat (25) begin
            @(negedge clk);
            if (rdy) seen = 1;
        end
        check({tag, " no rdy"}, seen, 0);
        if (m == 2'b00 && d >= 2) begin
            s = d - 1;
            r = (int'(mreg) >> s) | ((int'(w) & ((1 << s) - 1)) << (17 - s));
            mreg = 17'(r);
        end
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [16:0] w;
        logic [16:0] exp_so;
        int          exp_lat;
    } vec_t;

    vec_t        tbl [28];
    logic [16:0] sos [28];
    logic [16:0] sw;
    logic [8:0]  pool [16];

    initial begin
        tbl[0]  = '{2'b00, 17'h00458, 17'h0, 19};
        tbl[1]  = '{2'b11, 17'h0,     17'h0, 3};
        tbl[2]  = '{2'b00, 17'h00400, 17'h0, 19};
        tbl[3]  = '{2'b01, 17'h0,     17'h0, 3};
        tbl[4]  = '{2'b10, 17'h0,     17'h00458, 19};
        tbl[5]  = '{2'b00, 17'h00500, 17'h0, 19};
        tbl[6]  = '{2'b11, 17'h0,     17'h0, 3};
        tbl[7]  = '{2'b00, 17'h005FF, 17'h0, 19};
        tbl[8]  = '{2'b01, 17'h0,     17'h0, 3};
        tbl[9]  = '{2'b10, 17'h0,     17'h00500, 19};
        tbl[10] = '{2'b00, 17'h00671, 17'h0, 19};
        tbl[11] = '{2'b11, 17'h0,     17'h0, 3};
        tbl[12] = '{2'b00, 17'h00701, 17'h0, 19};
        tbl[13] = '{2'b11, 17'h0,     17'h0, 3};
        tbl[14] = '{2'b00, 17'h00600, 17'h0, 19};
        tbl[15] = '{2'b01, 17'h0,     17'h0, 3};
        tbl[16] = '{2'b10, 17'h0,     17'h00671, 19};
        tbl[17] = '{2'b00, 17'h00700, 17'h0, 19};
        tbl[18] = '{2'b01, 17'h0,     17'h0, 3};
        tbl[19] = '{2'b10, 17'h0,     17'h00701, 19};
        tbl[20] = '{2'b00, 17'h1FFA5, 17'h0, 19};
        tbl[21] = '{2'b11, 17'h0,     17'h0, 3};
        tbl[22] = '{2'b00, 17'h1FF00, 17'h0, 19};
        tbl[23] = '{2'b01, 17'h0,     17'h0, 3};
        tbl[24] = '{2'b10, 17'h0,     17'h1FFA5, 19};
        tbl[25] = '{2'b00, 17'h000AB, 17'h0, 19};
        tbl[26] = '{2'b10, 17'h0,     17'h000AB, 19};
        tbl[27] = '{2'b10, 17'h0,     17'h000AB, 19};

        mreg = '0;
        rst_n = 1'b0;
        bgn = 1'b1;
        load_n = 1'b0;
        mode = 2'b01;
        repeat (2) begin
            @(negedge clk);
            check("reset rdy", int'(rdy), 0);
            check("reset so", int'(so), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bgn = 1'b0;
        load_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post reset rdy", int'(rdy), 0);
        end

        for (int i = 0; i < 28; i++) begin
            run_cmd(tbl[i].m, tbl[i].w, $sformatf("vec%0d", i),
                    tbl[i].exp_so, tbl[i].exp_lat, tbl[i].m == 2'b10, sos[i]);
            model_apply(tbl[i].m, tbl[i].w);
        end
        check("pair 0x004 le16", int'({sos[9][7:0], sos[4][7:0]}), 88);
        check("pair 0x006 le16", int'({sos[19][7:0], sos[16][7:0]}), 369);

        do_cmd(2'b00, 17'h006EE, "abt setup", sw);
        abort_cmd(2'b00, 17'h12345, 9, "abort shift-in");
        do_cmd(2'b10, 17'h0, "abt partial", sw);
        do_cmd(2'b00, 17'h006EE, "abt setup2", sw);
        abort_cmd(2'b11, 17'h0, 0, "abort wr arm");
        abort_cmd(2'b11, 17'h0, 1, "abort wr access");
        do_cmd(2'b00, 17'h00600, "abt addr", sw);
        do_cmd(2'b01, 17'h0, "abt read", sw);
        do_cmd(2'b10, 17'h0, "abt verify", sw);

        do_cmd(2'b00, 17'h007EE, "rst setup", sw);
        @(posedge clk);
        #1;
        mode = 2'b11;
        bgn = 1'b1;
        load_n = 1'b0;
        @(posedge clk);
        #1;
        load_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid reset rdy", int'(rdy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bgn = 1'b0;
        mreg = '0;
        do_cmd(2'b10, 17'h0, "rst reg clear", sw);
        do_cmd(2'b00, 17'h00700, "rst addr", sw);
        do_cmd(2'b01, 17'h0, "rst read", sw);
        do_cmd(2'b10, 17'h0, "rst verify", sw);

        for (int i = 0; i < 16; i++) begin
            pool[i] = 9'($urandom);
            do_cmd(2'b00, {pool[i], 8'($urandom)}, "rnd init si", sw);
            do_cmd(2'b11, 17'h0, "rnd init wr", sw);
        end
        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 3))
                0: do_cmd(2'b00, {pool[$urandom_range(0, 15)], 8'($urandom)},
                          "rnd si", sw);
                1: do_cmd(2'b11, 17'h0, "rnd wr", sw);
                2: do_cmd(2'b01, 17'h0, "rnd rd", sw);
                default: do_cmd(2'b10, 17'h0, "rnd so", sw);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
